imm_encoder: RTL

Pipelined RISC-V instruction encoder that packs an opcode, register fields and a 32-bit signed immediate into a 32-bit instruction word. It performs the inverse of the decode-stage immediate extraction, and must round-trip exactly with it. It is used by the instruction-memory loader and the self-check bench to build program images. It also validates that each immediate is representable in the selected format.

---
 rtl/riscv_pkg.sv | 45 ++++
 rtl/imm_range_check.sv | 25 ++
 rtl/imm_encoder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding definitions: immediate format codes, opcode constants,
// immediate range limits and the encoder request bundle.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // Byte-offset limits; B and J also require an even offset.
  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed BIMM_MIN  = -4096;
  localparam int signed BIMM_MAX  = 4094;
  localparam int signed JIMM_MIN  = -1048576;
  localparam int signed JIMM_MAX  = 1048574;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_req_t;

  function automatic logic fmt_legal(input logic [2:0] fmt);
    return fmt <= FMT_J;
  endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational check that a signed immediate fits (and is aligned for) the
// selected instruction format. Illegal formats are flagged by the caller.
module imm_range_check
  import riscv_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] imm,
  output logic        err
);

  logic signed [31:0] simm;
  assign simm = $signed(imm);

  always_comb begin
    err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: err = (simm < IMM12_MIN) || (simm > IMM12_MAX);
      FMT_B:        err = (simm < BIMM_MIN) || (simm > BIMM_MAX) || imm[0];
      FMT_J:        err = (simm < JIMM_MIN) || (simm > JIMM_MAX) || imm[0];
      FMT_U:        err = (imm[11:0] != 12'd0);
      default:      err = 1'b0;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage RISC-V instruction encoder (S1: capture + immediate check, S2: field
// assembly / output register). IMM_ENCODER_RANGE_CHECK_EN enables range checks.
module imm_encoder
  import riscv_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fmt,
  input  logic [6:0]           in_opcode,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [6:0]           in_funct7,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  enc_req_t    in_req;
  enc_req_t    s1_req;
  logic        s1_valid;
  logic        s1_err;
  logic        s1_err_d;
  logic        s2_load;
  logic        accept;
  logic [31:0] instr_d;

  assign in_req = '{fmt:    in_fmt,
                    opcode: in_opcode,
                    rd:     in_rd,
                    rs1:    in_rs1,
                    rs2:    in_rs2,
                    funct3: in_funct3,
                    funct7: in_funct7,
                    imm:    in_imm};

  // S2 takes S1 whenever it is empty or its result is leaving this cycle.
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !rst && (!s1_valid || s2_load);
  assign accept   = in_valid && in_ready;

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  logic range_err;

  imm_range_check u_range_check (
    .fmt (in_fmt),
    .imm (in_imm),
    .err (range_err)
  );

  assign s1_err_d = !fmt_legal(in_fmt) || range_err;
`else
  assign s1_err_d = !fmt_legal(in_fmt);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // NOTE: the S1 payload carries no reset; it is only ever observed while
  // s1_valid is set, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_req <= in_req;
      s1_err <= s1_err_d;
    end
  end

  always_comb begin
    // NOTE: assign a default before the case so no path infers a latch.
    instr_d = '0;
    case (s1_req.fmt)
      FMT_R: instr_d = {s1_req.funct7, s1_req.rs2, s1_req.rs1, s1_req.funct3,
                        s1_req.rd, s1_req.opcode};
      FMT_I: instr_d = {s1_req.imm[11:0], s1_req.rs1, s1_req.funct3,
                        s1_req.rd, s1_req.opcode};
      FMT_S: instr_d = {s1_req.imm[11:5], s1_req.rs2, s1_req.rs1, s1_req.funct3,
                        s1_req.imm[4:0], s1_req.opcode};
      FMT_B: instr_d = {s1_req.imm[12], s1_req.imm[10:5], s1_req.rs2, s1_req.rs1,
                        s1_req.funct3, s1_req.imm[4:1], s1_req.imm[11],
                        s1_req.opcode};
      FMT_U: instr_d = {s1_req.imm[31:12], s1_req.rd, s1_req.opcode};
      FMT_J: instr_d = {s1_req.imm[20], s1_req.imm[10:1], s1_req.imm[11],
                        s1_req.imm[19:12], s1_req.rd, s1_req.opcode};
      default: instr_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_instr <= instr_d;
      out_err   <= s1_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Counts errored results as they are handed off; sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_err && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule
